// File: rtl/ptw_arbiter_if.sv
// Bundle between the two translation requesters, the page-table walker and
// ptw_arbiter.
//   ptbr/flush             : invalidation sources for the per-port caches
//   ireq_*/iresp_*         : instruction-fetch translation request/response
//   dreq_*/dresp_*         : data-memory translation request/response
//   walk_enable/walk_vaddr : arbiter -> walker command
//   walk_ready/walk_pte    : walker -> arbiter completion and leaf PTE
// slave  : arbiter view
// master : environment view (requesters + walker)
interface ptw_arbiter_if #(
  parameter int BUS_DATA_WIDTH = 64
);
  logic [BUS_DATA_WIDTH-1:0] ptbr;
  logic                      flush;
  logic                      ireq_valid;
  logic [BUS_DATA_WIDTH-1:0] ireq_vaddr;
  logic                      iresp_valid;
  logic [BUS_DATA_WIDTH-1:0] iresp_paddr;
  logic                      dreq_valid;
  logic [BUS_DATA_WIDTH-1:0] dreq_vaddr;
  logic                      dresp_valid;
  logic [BUS_DATA_WIDTH-1:0] dresp_paddr;
  logic                      walk_enable;
  logic [BUS_DATA_WIDTH-1:0] walk_vaddr;
  logic                      walk_ready;
  logic [BUS_DATA_WIDTH-1:0] walk_pte;

  modport slave (
    input  ptbr, flush,
    input  ireq_valid, ireq_vaddr, dreq_valid, dreq_vaddr,
    output iresp_valid, iresp_paddr, dresp_valid, dresp_paddr,
    output walk_enable, walk_vaddr,
    input  walk_ready, walk_pte
  );

  modport master (
    output ptbr, flush,
    output ireq_valid, ireq_vaddr, dreq_valid, dreq_vaddr,
    input  iresp_valid, iresp_paddr, dresp_valid, dresp_paddr,
    input  walk_enable, walk_vaddr,
    output walk_ready, walk_pte
  );
endinterface

// File: rtl/ptw_arbiter.sv
// Shares one page-table walker between the I and D translation ports.
// Each port has a one-entry last-translation cache; a hit in IDLE answers
// the next cycle without a walk. Misses are walked one at a time with
// round-robin arbitration on ties. Leaf PTE -> paddr = {pte[61:10], vaddr[11:0]}.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : ptw_arbiter_if.slave (requests, responses, walker handshake)
module ptw_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int VPN_HI         = 47
) (
  input logic            clk,
  input logic            reset,
  ptw_arbiter_if.slave   bus
);
  localparam int VPN_W = VPN_HI - 11;
  localparam int PPN_W = 52;

  typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, DONE} state_t;
  typedef enum logic {GNT_I, GNT_D} port_t;

  state_t                    r_state;
  port_t                     r_grant;
  port_t                     r_last_grant;
  logic [BUS_DATA_WIDTH-1:0] r_ptbr;
  logic                      r_inval_pending;
  logic [BUS_DATA_WIDTH-1:0] r_walk_vaddr;
  logic                      r_walk_enable;
  logic [PPN_W-1:0]          r_pte_ppn;

  logic                      r_iresp_valid;
  logic [BUS_DATA_WIDTH-1:0] r_iresp_paddr;
  logic                      r_dresp_valid;
  logic [BUS_DATA_WIDTH-1:0] r_dresp_paddr;

  logic                      r_ic_valid;
  logic [VPN_W-1:0]          r_ic_vpn;
  logic [PPN_W-1:0]          r_ic_ppn;
  logic                      r_dc_valid;
  logic [VPN_W-1:0]          r_dc_vpn;
  logic [PPN_W-1:0]          r_dc_ppn;

  logic                      w_inval;
  logic [VPN_W-1:0]          w_ivpn;
  logic [VPN_W-1:0]          w_dvpn;
  logic                      w_ihit;
  logic                      w_dhit;
  logic                      w_imiss;
  logic                      w_dmiss;
  port_t                     w_grant;
  logic [PPN_W-1:0]          w_ppn;
  logic                      w_unused;

  assign w_inval = bus.flush | (bus.ptbr != r_ptbr);
  assign w_ivpn  = bus.ireq_vaddr[VPN_HI:12];
  assign w_dvpn  = bus.dreq_vaddr[VPN_HI:12];
  assign w_ppn   = bus.walk_pte[61:10];

  // A request is still held high in the cycle its response pulses; masking
  // by the response flag keeps it from being served twice.
  assign w_ihit  = bus.ireq_valid & ~r_iresp_valid & r_ic_valid & ~w_inval & (r_ic_vpn == w_ivpn);
  assign w_dhit  = bus.dreq_valid & ~r_dresp_valid & r_dc_valid & ~w_inval & (r_dc_vpn == w_dvpn);
  assign w_imiss = bus.ireq_valid & ~r_iresp_valid & ~w_ihit;
  assign w_dmiss = bus.dreq_valid & ~r_dresp_valid & ~w_dhit;

  assign w_grant = (w_imiss & w_dmiss) ? ((r_last_grant == GNT_D) ? GNT_I : GNT_D)
                                       : (w_imiss ? GNT_I : GNT_D);

  assign w_unused = ^{bus.walk_pte[BUS_DATA_WIDTH-1:62], bus.walk_pte[9:0],
                      bus.ireq_vaddr[BUS_DATA_WIDTH-1:VPN_HI+1],
                      bus.dreq_vaddr[BUS_DATA_WIDTH-1:VPN_HI+1],
                      r_walk_vaddr[BUS_DATA_WIDTH-1:VPN_HI+1]};

  assign bus.iresp_valid = r_iresp_valid;
  assign bus.iresp_paddr = r_iresp_paddr;
  assign bus.dresp_valid = r_dresp_valid;
  assign bus.dresp_paddr = r_dresp_paddr;
  assign bus.walk_enable = r_walk_enable;
  assign bus.walk_vaddr  = r_walk_vaddr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_grant         <= GNT_I;
      r_last_grant    <= GNT_D;
      r_ptbr          <= '0;
      r_inval_pending <= 1'b0;
      r_walk_vaddr    <= '0;
      r_walk_enable   <= 1'b0;
      r_pte_ppn       <= '0;
      r_iresp_valid   <= 1'b0;
      r_iresp_paddr   <= '0;
      r_dresp_valid   <= 1'b0;
      r_dresp_paddr   <= '0;
      r_ic_valid      <= 1'b0;
      r_ic_vpn        <= '0;
      r_ic_ppn        <= '0;
      r_dc_valid      <= 1'b0;
      r_dc_vpn        <= '0;
      r_dc_ppn        <= '0;
    end else begin
      r_ptbr        <= bus.ptbr;
      r_iresp_valid <= 1'b0;
      r_dresp_valid <= 1'b0;
      r_walk_enable <= 1'b0;

      if (w_inval) begin
        r_ic_valid <= 1'b0;
        r_dc_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_ihit) begin
            r_iresp_valid <= 1'b1;
            r_iresp_paddr <= BUS_DATA_WIDTH'({r_ic_ppn, bus.ireq_vaddr[11:0]});
          end
          if (w_dhit) begin
            r_dresp_valid <= 1'b1;
            r_dresp_paddr <= BUS_DATA_WIDTH'({r_dc_ppn, bus.dreq_vaddr[11:0]});
          end
          if (w_imiss | w_dmiss) begin
            r_grant         <= w_grant;
            r_last_grant    <= w_grant;
            r_walk_vaddr    <= (w_grant == GNT_I) ? bus.ireq_vaddr : bus.dreq_vaddr;
            r_walk_enable   <= 1'b1;
            r_inval_pending <= 1'b0;
            r_state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (w_inval) r_inval_pending <= 1'b1;
          r_state <= ARM;
        end
        ARM: begin
          // walk_ready may still be high from the previous walk; completion
          // only counts after the walker has visibly left READY.
          if (w_inval) r_inval_pending <= 1'b1;
          if (!bus.walk_ready) r_state <= WAIT;
        end
        WAIT: begin
          if (w_inval) r_inval_pending <= 1'b1;
          if (bus.walk_ready) begin
            r_pte_ppn <= w_ppn;
            if (r_grant == GNT_I) begin
              r_iresp_valid <= 1'b1;
              r_iresp_paddr <= BUS_DATA_WIDTH'({w_ppn, r_walk_vaddr[11:0]});
            end else begin
              r_dresp_valid <= 1'b1;
              r_dresp_paddr <= BUS_DATA_WIDTH'({w_ppn, r_walk_vaddr[11:0]});
            end
            r_state <= DONE;
          end
        end
        DONE: begin
          if (!r_inval_pending && !w_inval) begin
            if (r_grant == GNT_I) begin
              r_ic_valid <= 1'b1;
              r_ic_vpn   <= r_walk_vaddr[VPN_HI:12];
              r_ic_ppn   <= r_pte_ppn;
            end else begin
              r_dc_valid <= 1'b1;
              r_dc_vpn   <= r_walk_vaddr[VPN_HI:12];
              r_dc_ppn   <= r_pte_ppn;
            end
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ptw_arbiter.sv
// Scoreboard bench for ptw_arbiter: requesters push expected paddrs computed
// from an abstract page-table/cache model; a monitor pops on each response.
module tb_ptw_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ptw_arbiter_if #(.BUS_DATA_WIDTH(64)) bus();

  ptw_arbiter #(.BUS_DATA_WIDTH(64), .VPN_HI(47)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [63:0] iq[$];
  logic [63:0] dq[$];
  logic [63:0] walk_log[$];
  int walks = 0;
  int exp_walks = 0;
  int unsigned gen = 0;
  logic        mv[2];
  logic [35:0] mvpn[2];
  logic [51:0] mppn[2];
  bit w_rand = 1'b0;
  int w_drop = 0;
  int w_lat  = 2;

  // Page table: one fixed entry from the directed vectors, all others derive
  // from the VPN and the current translation generation.
  function automatic logic [51:0] pte_ppn(input logic [63:0] va, input int unsigned g);
    logic [35:0] vpn;
    logic [15:0] gl;
    vpn = va[47:12];
    gl  = 16'(g);
    if (vpn == 36'h0_0401_2345) return 52'h8_0001;
    return {gl, vpn ^ 36'h5_A5A5_A5A5};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_log(input string name, input int idx, input logic [63:0] exp);
    logic [63:0] v;
    if (walk_log.size() > idx) begin
      v = walk_log[idx];
      check(name, v, exp);
    end else begin
      tests++;
      fails++;
      $display("FAIL %s: only %0d walks logged, expected entry %0d", name, walk_log.size(), idx);
    end
  endtask

  // Monitor: compare every response pulse against the scoreboard.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (bus.iresp_valid === 1'b1) begin
        if (iq.size() == 0) begin
          tests++; fails++;
          $display("FAIL iresp_unexpected: got paddr %h, expected no response", bus.iresp_paddr);
        end else begin
          e = iq.pop_front();
          check("iresp_paddr", bus.iresp_paddr, e);
        end
      end
      if (bus.dresp_valid === 1'b1) begin
        if (dq.size() == 0) begin
          tests++; fails++;
          $display("FAIL dresp_unexpected: got paddr %h, expected no response", bus.dresp_paddr);
        end else begin
          e = dq.pop_front();
          check("dresp_paddr", bus.dresp_paddr, e);
        end
      end
      if (bus.walk_enable === 1'b1) begin
        walks++;
        walk_log.push_back(bus.walk_vaddr);
      end
    end
  end

  // Walker model: ready stays high until some cycles after enable, then low
  // for the walk latency, then high with the leaf PTE.
  initial begin
    logic [63:0] va;
    int unsigned g;
    int d;
    int l;
    bus.walk_ready = 1'b1;
    bus.walk_pte   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset !== 1'b1 && bus.walk_enable === 1'b1) begin
        va = bus.walk_vaddr;
        g  = gen;
        d  = w_rand ? int'($urandom_range(0, 2)) : w_drop;
        l  = w_rand ? int'($urandom_range(2, 5)) : w_lat;
        repeat (d) begin @(posedge clk); #1; end
        bus.walk_ready = 1'b0;
        repeat (l) begin @(posedge clk); #1; end
        bus.walk_pte   = {2'b00, pte_ppn(va, g), 10'h001};
        bus.walk_ready = 1'b1;
      end
    end
  end

  // Issue one request on port p (0=I, 1=D) and wait for its response.
  task automatic do_req(input int p, input logic [63:0] va, output int lat);
    logic [35:0] vpn;
    logic [51:0] ppn;
    bit done;
    vpn = va[47:12];
    if (mv[p] && mvpn[p] == vpn) begin
      ppn = mppn[p];
    end else begin
      ppn     = pte_ppn(va, gen);
      mv[p]   = 1'b1;
      mvpn[p] = vpn;
      mppn[p] = ppn;
      exp_walks++;
    end
    if (p == 0) begin
      iq.push_back({ppn, va[11:0]});
      bus.ireq_vaddr = va;
      bus.ireq_valid = 1'b1;
    end else begin
      dq.push_back({ppn, va[11:0]});
      bus.dreq_vaddr = va;
      bus.dreq_valid = 1'b1;
    end
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 300) begin
      @(negedge clk);
      lat++;
      if (((p == 0) ? bus.iresp_valid : bus.dresp_valid) === 1'b1) done = 1'b1;
    end
    if (p == 0) bus.ireq_valid = 1'b0;
    else        bus.dreq_valid = 1'b0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL port%0d_timeout: got no response in %0d cycles, expected one", p, lat);
    end
  endtask

  task automatic invalidate_model();
    mv[0] = 1'b0;
    mv[1] = 1'b0;
    gen++;
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    invalidate_model();
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  task automatic set_ptbr(input logic [63:0] v);
    bus.ptbr = v;
    invalidate_model();
    @(negedge clk);
  endtask

  task automatic do_reset(input bit chk);
    reset = 1'b1;
    bus.ireq_valid = 1'b0;
    bus.dreq_valid = 1'b0;
    bus.flush      = 1'b0;
    repeat (2) @(negedge clk);
    if (chk) begin
      check("rst_iresp_valid", 64'(bus.iresp_valid), 64'd0);
      check("rst_dresp_valid", 64'(bus.dresp_valid), 64'd0);
      check("rst_walk_enable", 64'(bus.walk_enable), 64'd0);
      check("rst_walk_vaddr",  bus.walk_vaddr, 64'd0);
      check("rst_iresp_paddr", bus.iresp_paddr, 64'd0);
      check("rst_dresp_paddr", bus.dresp_paddr, 64'd0);
    end
    reset = 1'b0;
    mv[0] = 1'b0;
    mv[1] = 1'b0;
    iq.delete();
    dq.delete();
    walk_log.delete();
    walks     = 0;
    exp_walks = 0;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [63:0] rand_va(input int p);
    logic [1:0]  page;
    logic [11:0] off;
    page = 2'($urandom_range(0, 3));
    off  = 12'($urandom);
    return {16'h0, (p == 0) ? 8'h1A : 8'h2D, 26'h0, page, off};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int lat_i;
    int lat_d;
    bus.ptbr       = 64'h1000;
    bus.flush      = 1'b0;
    bus.ireq_valid = 1'b0;
    bus.ireq_vaddr = '0;
    bus.dreq_valid = 1'b0;
    bus.dreq_vaddr = '0;
    reset          = 1'b1;
    @(negedge clk);
    do_reset(1'b1);

    // First miss on I, then a same-page hit.
    do_req(0, 64'h0000_0040_1234_5678, lat);
    check("t1_miss_latency", 64'(lat), 64'd4);
    check("t1_walks", 64'(walks), 64'd1);
    repeat (2) @(negedge clk);
    do_req(0, 64'h0000_0040_1234_5ABC, lat);
    check("t2_hit_latency", 64'(lat), 64'd1);
    check("t2_walks", 64'(walks), 64'd1);
    repeat (2) @(negedge clk);

    // Stale ready from the previous walk drops two cycles after enable.
    w_drop = 2; w_lat = 3;
    do_req(0, 64'h0000_0077_0000_0010, lat);
    check("t6_stale_ready_latency", 64'(lat), 64'd7);
    check("t6_walks", 64'(walks), 64'd2);
    w_drop = 0; w_lat = 2;

    // Tie after reset: I first, D one walk later; then alternation.
    do_reset(1'b0);
    fork
      do_req(0, 64'h0000_0011_1111_1000, lat_i);
      do_req(1, 64'h0000_0022_2222_2000, lat_d);
    join
    check_log("t3_first_grant_i", 0, 64'h0000_0011_1111_1000);
    check_log("t3_second_grant_d", 1, 64'h0000_0022_2222_2000);
    check("t3_d_wait", 64'(lat_d), 64'(lat_i + 5));
    repeat (2) @(negedge clk);
    do_req(0, 64'h0000_0033_3333_3000, lat);
    repeat (2) @(negedge clk);
    fork
      do_req(0, 64'h0000_0044_4444_4000, lat_i);
      do_req(1, 64'h0000_0055_5555_5000, lat_d);
    join
    check_log("t3_tie_grant_d", 3, 64'h0000_0055_5555_5000);
    check_log("t3_tie_then_i", 4, 64'h0000_0044_4444_4000);
    repeat (2) @(negedge clk);

    // Flush during WAIT: response delivered, not cached.
    do_reset(1'b0);
    w_lat = 6;
    fork
      do_req(0, 64'h0000_0066_6666_6123, lat);
      begin repeat (3) @(negedge clk); pulse_flush(); end
    join
    check("t4_flush_walk_latency", 64'(lat), 64'd8);
    w_lat = 2;
    repeat (2) @(negedge clk);
    do_req(0, 64'h0000_0066_6666_6456, lat);
    check("t4_rewalk_latency", 64'(lat), 64'd4);
    check("t4_walks", 64'(walks), 64'd2);
    repeat (2) @(negedge clk);

    // ptbr change while idle invalidates both caches.
    do_reset(1'b0);
    fork
      do_req(0, 64'h0000_0012_3450_0100, lat_i);
      do_req(1, 64'h0000_0067_8900_0200, lat_d);
    join
    repeat (2) @(negedge clk);
    fork
      do_req(0, 64'h0000_0012_3450_0300, lat_i);
      do_req(1, 64'h0000_0067_8900_0400, lat_d);
    join
    check("t5_i_hit_latency", 64'(lat_i), 64'd1);
    check("t5_d_hit_latency", 64'(lat_d), 64'd1);
    check("t5_walks_before", 64'(walks), 64'd2);
    repeat (2) @(negedge clk);
    set_ptbr(64'h2000);
    fork
      do_req(0, 64'h0000_0012_3450_0500, lat_i);
      do_req(1, 64'h0000_0067_8900_0600, lat_d);
    join
    check("t5_walks_after", 64'(walks), 64'd4);
    bus.ptbr = 64'h1000;
    repeat (2) @(negedge clk);

    // Randomized traffic on both ports; invalidations only while quiet.
    do_reset(1'b0);
    w_rand = 1'b1;
    for (int unsigned r = 0; r < 3; r++) begin
      fork
        begin
          int l0;
          for (int unsigned k = 0; k < 30; k++) begin
            do_req(0, rand_va(0), l0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
          end
        end
        begin
          int l1;
          for (int unsigned k = 0; k < 30; k++) begin
            do_req(1, rand_va(1), l1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
          end
        end
      join
      repeat (2) @(negedge clk);
      check("rand_walk_count", 64'(walks), 64'(exp_walks));
      if (r[0]) pulse_flush();
      else      set_ptbr(64'h1000 + 64'((r + 1) << 12));
      repeat (2) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(iq.size() + dq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ptw_arbiter.md
Name: ptw_arbiter

Overview:
- Shares the single page-table walker between the instruction-fetch (I) and data-memory (D) translation requesters.
- Sequences the walker's enable/ready handshake and converts the returned leaf PTE into a physical address.
- Keeps a one-entry last-translation cache per port, so repeated accesses to the same page skip the walk.
- Sits between the fetch/LSU stages and the walker; owns the walker's enable and virt_addr inputs.

Parameters:
BUS_DATA_WIDTH, 64, width of addresses, PTEs and ptbr
VPN_HI, 47, top virtual-address bit compared for cache hit (VPN = vaddr[VPN_HI:12])

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
ptbr  input  BUS_DATA_WIDTH  page-table base; any change invalidates both caches
flush  input  1  one-cycle pulse; invalidates both caches
ireq_valid  input  1  I-port translation request; held until iresp_valid
ireq_vaddr  input  BUS_DATA_WIDTH  I-port virtual address; stable while ireq_valid
iresp_valid  output  1  one-cycle pulse: iresp_paddr valid
iresp_paddr  output  BUS_DATA_WIDTH  I-port physical address
dreq_valid  input  1  D-port translation request; held until dresp_valid
dreq_vaddr  input  BUS_DATA_WIDTH  D-port virtual address
dresp_valid  output  1  one-cycle pulse: dresp_paddr valid
dresp_paddr  output  BUS_DATA_WIDTH  D-port physical address
walk_enable  output  1  drives walker enable
walk_vaddr  output  BUS_DATA_WIDTH  drives walker virt_addr; held for the whole walk
walk_ready  input  1  walker ready (stays high until the next enable)
walk_pte  input  BUS_DATA_WIDTH  walker phy_addr (leaf PTE)

Behaviour:
- Reset (async): all outputs 0; state IDLE; both cache valid bits 0; last_grant = D, so I wins the first tie.
- Address formation: paddr = {pte[61:10], vaddr[11:0]}. Cache entry = {valid, VPN, pte[61:10]}.
- Hit path: in IDLE, a port with req_valid whose cache entry is valid and matches VPN gets resp_valid in the next cycle; no walk is issued.
  - I and D may hit in the same cycle; both respond.
  - A hitting port is never granted a walk.
- States: IDLE, ISSUE, ARM, WAIT, DONE.
  - IDLE -> ISSUE when at least one valid requester misses.
    - Grant rule: if both miss, grant the port != last_grant; otherwise grant the missing port.
    - Latch the grant, set last_grant = grant, latch walk_vaddr from the granted port.
  - ISSUE: walk_enable = 1 for exactly one cycle; -> ARM.
  - ARM: wait for walk_ready == 0 (walker has left READY); -> WAIT. A stale ready high from a previous walk must not be taken as completion.
  - WAIT: on walk_ready == 1, capture walk_pte; -> DONE.
  - DONE: pulse the granted port's resp_valid with paddr; write that port's cache entry unless invalidated during the walk (see below); -> IDLE.
- Non-granted miss: keeps waiting. It is re-evaluated in IDLE the cycle after DONE and is then guaranteed the grant (round-robin), which bounds starvation to one walk.
- Invalidate: cache valid bits clear on the cycle after flush = 1 or ptbr != registered ptbr.
  - If this happens during ISSUE/ARM/WAIT/DONE, the in-flight walk still completes and is returned, but its result is NOT written to the cache (inval_pending flag).
- Invalidate and hit in the same IDLE cycle: the invalidate wins; the request is treated as a miss.
- Requester dropping req_valid mid-walk is illegal; the walk completes and the response pulse is still issued.
- walk_vaddr holds its value outside walks; walk_enable is 0 in all states except ISSUE.
- Latency:
  - hit: 1 cycle from req_valid to resp_valid.
  - miss: 3 + walker time (ISSUE, ARM, then DONE one cycle after walk_ready).
- Reset mid-walk: the arbiter returns to IDLE immediately; no response is issued. The walker shares the same reset.

Test Plan:
- Reset, then ireq_valid with vaddr 0x0000_0040_1234_5678; walker model returns pte 0x0000_0000_2000_0401 -> walk_enable one-cycle pulse; iresp_paddr 0x0000_0000_8000_1678; iresp_valid one cycle.
- Repeat the I request with vaddr 0x0000_0040_1234_5ABC -> iresp_valid one cycle later; paddr 0x0000_0000_8000_1ABC; walk_enable stays 0.
- I and D both miss in the same cycle after reset -> I walked first, D second; second DONE carries the D response; last_grant alternates on the next tie.
- Walk in progress, flush pulsed in WAIT -> response still delivered; the same vaddr afterwards causes a new walk (no cache hit).
- ptbr changes from 0x1000 to 0x2000 while idle with both caches valid -> next I and D requests both walk.
- Walker holds walk_ready high from the prior walk and drops it two cycles after enable -> arbiter stays in ARM and does not respond until ready re-rises.
